// File: rtl/lutram_bist_if.sv
`default_nettype none
// ============================================================================
// Module  : lutram_bist_if
// Brief   : Control/status and array-port bundle of the LUTRAM BIST sequencer.
// Revision: 1.0
// ============================================================================
interface lutram_bist_if #(
  parameter int ADDR_W = 13
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] first_err_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [9:0]        mem_wdat;
  logic [9:0]        mem_rdat;

  modport master (
    input  start, mem_rdat,
    output busy, done, pass, err_cnt, first_err_addr, mem_addr, mem_we, mem_wdat
  );

  modport slave (
    output start, mem_rdat,
    input  busy, done, pass, err_cnt, first_err_addr, mem_addr, mem_we, mem_wdat
  );
endinterface
`default_nettype wire

// File: rtl/lutram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lutram_bist_ctrl
// Brief   : Two-pass write/read-back march BIST over a LUTRAM stress array.
// Revision: 1.0
// ============================================================================
module lutram_bist_ctrl #(
  parameter int LUTRAM16X10 = 314,
  parameter int RD_LAT      = 0,
  parameter int ADDR_W      = $clog2(LUTRAM16X10*16)
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  lutram_bist_if.master bus
);

  localparam int                c_depth      = LUTRAM16X10 * 16;
  localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(c_depth - 1);
  localparam bit                c_no_drain   = (RD_LAT == 0);
  localparam logic [1:0]        c_drain_last = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_pass_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_drain_cnt;
  logic              r_we;
  logic [9:0]        r_wdat;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [15:0]       r_err_cnt;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              r_err_flag;

  logic              w_cmp_valid;
  logic [9:0]        w_cmp_exp;
  logic [ADDR_W-1:0] w_cmp_addr;
  logic              w_mismatch;
  logic [15:0]       w_err_cnt_next;
  logic              w_pass_end;

  // Address is zero-extended (or truncated) to the 10-bit data width first.
  function automatic logic [9:0] pat(input logic [ADDR_W-1:0] a, input logic p);
    return (10'(a) ^ 10'h155) ^ {10{p}};
  endfunction

  generate
    if (RD_LAT == 0) begin : g_comb_cmp
      assign w_cmp_valid = (r_state == S_READ);
      assign w_cmp_exp   = pat(r_addr, r_pass_idx);
      assign w_cmp_addr  = r_addr;
    end else begin : g_pipe_cmp
      logic              r_pv [RD_LAT];
      logic [9:0]        r_pe [RD_LAT];
      logic [ADDR_W-1:0] r_pa [RD_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < RD_LAT; i++) begin
            r_pv[i] <= 1'b0;
            r_pe[i] <= '0;
            r_pa[i] <= '0;
          end
        end else begin
          r_pv[0] <= (r_state == S_READ);
          r_pe[0] <= pat(r_addr, r_pass_idx);
          r_pa[0] <= r_addr;
          for (int i = 1; i < RD_LAT; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pe[i] <= r_pe[i-1];
            r_pa[i] <= r_pa[i-1];
          end
        end
      end

      assign w_cmp_valid = r_pv[RD_LAT-1];
      assign w_cmp_exp   = r_pe[RD_LAT-1];
      assign w_cmp_addr  = r_pa[RD_LAT-1];
    end
  endgenerate

  assign w_mismatch     = w_cmp_valid && (bus.mem_rdat != w_cmp_exp);
  assign w_err_cnt_next = (w_mismatch && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1 : r_err_cnt;
  // A pass ends on the last READ address, or on the last DRAIN cycle when reads are pipelined.
  assign w_pass_end     = (c_no_drain && (r_state == S_READ) && (r_addr == c_last_addr)) ||
                          (!c_no_drain && (r_state == S_DRAIN) && (r_drain_cnt == c_drain_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_pass_idx       <= 1'b0;
      r_addr           <= '0;
      r_drain_cnt      <= '0;
      r_we             <= 1'b0;
      r_wdat           <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_err_flag       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_mismatch) begin
        r_err_cnt <= w_err_cnt_next;
        if (!r_err_flag) begin
          r_err_flag       <= 1'b1;
          r_first_err_addr <= w_cmp_addr;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state          <= S_WRITE;
            r_pass_idx       <= 1'b0;
            r_addr           <= '0;
            r_we             <= 1'b1;
            r_wdat           <= pat('0, 1'b0);
            r_busy           <= 1'b1;
            r_err_cnt        <= '0;
            r_first_err_addr <= '0;
            r_err_flag       <= 1'b0;
          end
        end
        S_WRITE: begin
          if (r_addr == c_last_addr) begin
            r_state <= S_READ;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdat  <= '0;
          end else begin
            r_addr <= r_addr + 1'b1;
            r_wdat <= pat(r_addr + 1'b1, r_pass_idx);
          end
        end
        S_READ: begin
          if (r_addr == c_last_addr) begin
            if (!c_no_drain) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
            end
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: r_drain_cnt <= r_drain_cnt + 2'd1;
        S_DONE:  r_state     <= S_IDLE;
        default: r_state     <= S_IDLE;
      endcase

      if (w_pass_end) begin
        if (!r_pass_idx) begin
          r_state    <= S_WRITE;
          r_pass_idx <= 1'b1;
          r_addr     <= '0;
          r_we       <= 1'b1;
          r_wdat     <= pat('0, 1'b1);
        end else begin
          r_state <= S_DONE;
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_pass  <= (w_err_cnt_next == 16'd0);
        end
      end
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.err_cnt        = r_err_cnt;
  assign bus.first_err_addr = r_first_err_addr;
  assign bus.mem_addr       = r_addr;
  assign bus.mem_we         = r_we;
  assign bus.mem_wdat       = r_wdat;

endmodule
`default_nettype wire

// File: tb/tb_lutram_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lutram_bist_ctrl
// Brief   : Self-checking bench: three BIST configurations with faulty memory models.
// Revision: 1.0
// ============================================================================
module tb_lutram_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lutram_bist_if #(.ADDR_W(5))  if0 ();
  lutram_bist_if #(.ADDR_W(5))  if2 ();
  lutram_bist_if #(.ADDR_W(13)) ifb ();

  lutram_bist_ctrl #(.LUTRAM16X10(2),   .RD_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
  lutram_bist_ctrl #(.LUTRAM16X10(2),   .RD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
  lutram_bist_ctrl #(.LUTRAM16X10(314), .RD_LAT(0)) u_dutb (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

  // Fault model: 0 = ideal, 1 = stuck bit at one address, 2 = array reads all zero.
  int   f_mode = 0;
  int   f_addr = 0;
  int   f_bit  = 0;
  logic f_val  = 1'b0;

  function automatic logic [9:0] fault_fn(input int a, input logic [9:0] d, input int m,
                                          input int fa, input int fb, input logic fv);
    logic [9:0] r;
    r = d;
    if (m == 2) r = '0;
    else if (m == 1 && a == fa) r[fb] = fv;
    return r;
  endfunction

  logic [9:0] mem0 [32];
  logic [9:0] mem2 [32];
  logic [9:0] memb [5024];
  logic [4:0] a2_d1, a2_d2;

  always @(posedge clk) begin
    if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdat;
    if (if2.mem_we) mem2[if2.mem_addr] <= if2.mem_wdat;
    if (ifb.mem_we) memb[ifb.mem_addr] <= ifb.mem_wdat;
    a2_d1 <= if2.mem_addr;
    a2_d2 <= a2_d1;
  end

  always_comb if0.mem_rdat = fault_fn(int'(if0.mem_addr), mem0[if0.mem_addr], f_mode, f_addr, f_bit, f_val);
  always_comb if2.mem_rdat = fault_fn(int'(a2_d2), mem2[a2_d2], f_mode, f_addr, f_bit, f_val);
  always_comb ifb.mem_rdat = memb[ifb.mem_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: write pattern, read it back through the fault, count differences.
  function automatic logic [9:0] tpat(input int a, input int p);
    logic [9:0] x;
    x = 10'(a);
    return (x ^ 10'h155) ^ ((p != 0) ? 10'h3FF : 10'h000);
  endfunction

  function automatic void ref_model(input int depth, output int ecnt, output int first);
    logic [9:0] w;
    ecnt  = 0;
    first = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < depth; a++) begin
        w = tpat(a, p);
        if (fault_fn(a, w, f_mode, f_addr, f_bit, f_val) != w) begin
          if (ecnt == 0) first = a;
          if (ecnt < 65535) ecnt++;
        end
      end
  endfunction

  typedef struct {
    logic busy, done, pass, we;
    int   err, first, addr, wdat;
  } obs_t;

  function automatic obs_t sample(input int sel);
    obs_t o;
    case (sel)
      0: o = '{if0.busy, if0.done, if0.pass, if0.mem_we, int'(if0.err_cnt),
               int'(if0.first_err_addr), int'(if0.mem_addr), int'(if0.mem_wdat)};
      1: o = '{if2.busy, if2.done, if2.pass, if2.mem_we, int'(if2.err_cnt),
               int'(if2.first_err_addr), int'(if2.mem_addr), int'(if2.mem_wdat)};
      default: o = '{ifb.busy, ifb.done, ifb.pass, ifb.mem_we, int'(ifb.err_cnt),
               int'(ifb.first_err_addr), int'(ifb.mem_addr), int'(ifb.mem_wdat)};
    endcase
    return o;
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: if0.start = v;
      1: if2.start = v;
      default: ifb.start = v;
    endcase
  endtask

  // Start is driven in cycle 0; returns the cycle in which done is seen (-1 on timeout).
  task automatic run_test(input int sel, output int done_cyc, output obs_t fin,
                          output int busy_cyc, output int we_cyc, output int max_addr);
    obs_t o;
    done_cyc = -1;
    busy_cyc = 0;
    we_cyc   = 0;
    max_addr = 0;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    for (int c = 1; c < 30000; c++) begin
      o = sample(sel);
      if (o.done) begin
        done_cyc = c;
        break;
      end
      if (o.busy) busy_cyc++;
      if (o.we) we_cyc++;
      if (o.addr > max_addr) max_addr = o.addr;
      @(posedge clk);
      #1;
    end
    fin = sample(sel);
  endtask

  typedef struct {
    string nm;
    int sel, fmode, faddr, fbit;
    logic fval;
    int exp_err, exp_first;
    logic exp_pass;
    int exp_done;
  } vec_t;

  vec_t vecs [5];

  initial begin
    obs_t o;
    int dc, bc, wc, ma, e_err, e_first, lat;

    vecs[0] = '{"T1_ideal",     0, 0, 0,  0, 1'b0, 0,  0,  1'b1, 129};
    vecs[1] = '{"T2_sa1_a5b0",  0, 1, 5,  0, 1'b1, 1,  5,  1'b0, 129};
    vecs[2] = '{"T3_lat2",      1, 0, 0,  0, 1'b0, 0,  0,  1'b1, 133};
    vecs[3] = '{"T3_sa0_a31b9", 1, 1, 31, 9, 1'b0, 1,  31, 1'b0, 133};
    vecs[4] = '{"T6_zero",      0, 2, 0,  0, 1'b0, 64, 0,  1'b0, 129};

    if0.start = 1'b0;
    if2.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = sample(0);
    check("rst_busy", int'(o.busy), 0);
    check("rst_done", int'(o.done), 0);
    check("rst_pass", int'(o.pass), 0);
    check("rst_err",  o.err, 0);
    check("rst_addr", o.addr, 0);
    check("rst_we",   int'(o.we), 0);
    check("rst_wdat", o.wdat, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      f_mode = vecs[i].fmode;
      f_addr = vecs[i].faddr;
      f_bit  = vecs[i].fbit;
      f_val  = vecs[i].fval;
      run_test(vecs[i].sel, dc, o, bc, wc, ma);
      check({vecs[i].nm, "_done_cyc"}, dc, vecs[i].exp_done);
      check({vecs[i].nm, "_busy_cyc"}, bc, vecs[i].exp_done - 1);
      check({vecs[i].nm, "_err_cnt"},  o.err, vecs[i].exp_err);
      check({vecs[i].nm, "_first"},    o.first, vecs[i].exp_first);
      check({vecs[i].nm, "_pass"},     int'(o.pass), int'(vecs[i].exp_pass));
      @(posedge clk);
      #1;
      o = sample(vecs[i].sel);
      check({vecs[i].nm, "_done_pulse"}, int'(o.done), 0);
      check({vecs[i].nm, "_hold_err"},   o.err, vecs[i].exp_err);
    end

    // Second start mid-test is ignored; async reset aborts without done.
    f_mode = 0;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 50; c++) begin
      if (c == 41) begin
        o = sample(0);
        check("T4_addr_c41", o.addr, 8);
        check("T4_we_c41",   int'(o.we), 0);
        check("T4_busy_c41", int'(o.busy), 1);
      end
      if (c == 50) begin
        #1;
        rst_n = 1'b0;
        #1;
        o = sample(0);
        check("T4_rst_busy", int'(o.busy), 0);
        check("T4_rst_addr", o.addr, 0);
        check("T4_rst_we",   int'(o.we), 0);
        check("T4_rst_err",  o.err, 0);
        check("T4_rst_pass", int'(o.pass), 0);
      end else begin
        @(negedge clk);
        if0.start = (c == 40);
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      o = sample(0);
      if (o.done || o.busy) bc++;
    end
    check("T4_no_done_after_rst", bc, 0);
    run_test(0, dc, o, bc, wc, ma);
    check("T4_rerun_done_cyc", dc, 129);
    check("T4_rerun_pass", int'(o.pass), 1);

    // Full-size array: address bound and write-enable duty.
    run_test(2, dc, o, bc, wc, ma);
    check("T5_done_cyc", dc, 1 + 2 * (2 * 5024));
    check("T5_we_cycles", wc, 10048);
    check("T5_max_addr", ma, 5023);
    check("T5_pass", int'(o.pass), 1);
    check("T5_err", o.err, 0);

    // Randomised faults against the reference model.
    for (int r = 0; r < 10; r++) begin
      int sel;
      sel    = int'($urandom_range(0, 1));
      lat    = (sel == 1) ? 2 : 0;
      f_mode = int'($urandom_range(0, 2));
      f_addr = int'($urandom_range(0, 31));
      f_bit  = int'($urandom_range(0, 9));
      f_val  = 1'($urandom_range(0, 1));
      ref_model(32, e_err, e_first);
      run_test(sel, dc, o, bc, wc, ma);
      check("rnd_done_cyc", dc, 1 + 2 * (64 + lat));
      check("rnd_err_cnt",  o.err, e_err);
      check("rnd_first",    o.first, e_first);
      check("rnd_pass",     int'(o.pass), (e_err == 0) ? 1 : 0);
      @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
